// File: rtl/spi_cordic_framer.sv
// -----------------------------------------------------------------------------
// spi_cordic_framer
//
// Byte-level command framer between an SPI slave byte interface and a CORDIC
// core. Received bytes are assembled into a write frame
//   byte0 = command (bits [7:6] opcode), byte1..2 = A (MSB first),
//   byte3..4 = B (MSB first) [, byte5 = XOR of bytes 0..4]
// and the core is launched with a single-cycle start pulse. Core results are
// captured on core_done and served back, together with a status byte, as
// transmit bytes: status, X[15:8], X[7:0], Y[15:8], Y[7:0], then 0x00.
//
// Status byte = {core_busy, done, err, abort, 4'b0000}; done/err/abort are
// sticky and cleared by the tx_req that completes the status byte.
//
// Optional feature: define SPI_FRAME_CHECKSUM_EN to require a sixth checksum
// byte on write frames; a mismatch sets err and suppresses the launch.
//
// Ports
//   clk, rst         : clock, asynchronous active-high reset
//   cs_n             : raw SPI chip select (synchronized here); rising = EOF
//   rx_data/rx_valid : received byte with its 1-cycle strobe
//   tx_req           : 1-cycle pulse, current tx_data byte has been shifted out
//   tx_data          : registered byte to transmit next
//   core_op/a/b      : latched opcode and operands for the core
//   core_start       : 1-cycle launch pulse
//   core_busy        : core is computing
//   core_done        : 1-cycle pulse, core_x/core_y valid
//   core_x/core_y    : core results
// -----------------------------------------------------------------------------
module spi_cordic_framer #(
  parameter int DATA_WIDTH    = 8,   // SPI byte width, must be 8
  parameter int OPERAND_WIDTH = 16   // two bytes per operand/result
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs_n,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_valid,
  input  logic                     tx_req,
  output logic [DATA_WIDTH-1:0]    tx_data,
  output logic [1:0]               core_op,
  output logic [OPERAND_WIDTH-1:0] core_a,
  output logic [OPERAND_WIDTH-1:0] core_b,
  output logic                     core_start,
  input  logic                     core_busy,
  input  logic                     core_done,
  input  logic [OPERAND_WIDTH-1:0] core_x,
  input  logic [OPERAND_WIDTH-1:0] core_y
);

`ifdef SPI_FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_CMD, S_A1, S_A0, S_B1, S_B0, S_CHK, S_LAUNCH, S_DISCARD
  } state_t;
`else
  typedef enum logic [2:0] {
    S_CMD, S_A1, S_A0, S_B1, S_B0, S_LAUNCH, S_DISCARD
  } state_t;
`endif

  localparam logic [2:0] RD_LAST = 3'd5;  // saturation point, serves 0x00

  // ---------------------------------------------------------------------------
  // Chip-select synchronizer and end-of-frame detect. The flops reset to the
  // idle (deselected) level so leaving reset never looks like a frame end.
  // ---------------------------------------------------------------------------
  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic eof_pulse;

  assign eof_pulse = cs_sync_q & ~cs_prev_q;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                   state_q, state_d;
  logic                     eof_seen_q, eof_seen_d;  // EOF consumed on launch byte
  logic [1:0]               op_q, op_d;
  logic [OPERAND_WIDTH-1:0] a_q, a_d;
  logic [OPERAND_WIDTH-1:0] b_q, b_d;
`ifdef SPI_FRAME_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]    chk_q, chk_d;
`endif
  logic [1:0]               core_op_q, core_op_d;
  logic [OPERAND_WIDTH-1:0] core_a_q, core_a_d;
  logic [OPERAND_WIDTH-1:0] core_b_q, core_b_d;

  logic [OPERAND_WIDTH-1:0] x_q, x_d;
  logic [OPERAND_WIDTH-1:0] y_q, y_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     abort_q, abort_d;
  logic [2:0]               rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;

  logic                     err_set, abort_set, partial_frame, rd_clear;
  logic [DATA_WIDTH-1:0]    status_byte;

  // ---------------------------------------------------------------------------
  // Frame FSM: next state, staging registers and launch outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d       = state_q;
    eof_seen_d    = 1'b0;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
`ifdef SPI_FRAME_CHECKSUM_EN
    chk_d         = chk_q;
`endif
    core_op_d     = core_op_q;
    core_a_d      = core_a_q;
    core_b_d      = core_b_q;
    err_set       = 1'b0;
    abort_set     = 1'b0;
    partial_frame = 1'b0;

    case (state_q)
      S_CMD: begin
        if (rx_valid) begin
          case (rx_data[DATA_WIDTH-1 -: 2])
            2'b00, 2'b01: begin
              if (core_busy) begin
                err_set = 1'b1;
                state_d = S_DISCARD;
              end else begin
                op_d    = rx_data[DATA_WIDTH-1 -: 2];
                state_d = S_A1;
              end
            end
            2'b10: begin
              err_set = 1'b1;
              state_d = S_DISCARD;
            end
            default: state_d = S_DISCARD;  // READ: rest of frame is ignored
          endcase
`ifdef SPI_FRAME_CHECKSUM_EN
          chk_d = rx_data;
`endif
        end
      end
      S_A1: begin
        if (rx_valid) begin
          a_d[OPERAND_WIDTH-1 -: DATA_WIDTH] = rx_data;
          state_d = S_A0;
`ifdef SPI_FRAME_CHECKSUM_EN
          chk_d = chk_q ^ rx_data;
`endif
        end
      end
      S_A0: begin
        if (rx_valid) begin
          a_d[DATA_WIDTH-1:0] = rx_data;
          state_d = S_B1;
`ifdef SPI_FRAME_CHECKSUM_EN
          chk_d = chk_q ^ rx_data;
`endif
        end
      end
      S_B1: begin
        if (rx_valid) begin
          b_d[OPERAND_WIDTH-1 -: DATA_WIDTH] = rx_data;
          state_d = S_B0;
`ifdef SPI_FRAME_CHECKSUM_EN
          chk_d = chk_q ^ rx_data;
`endif
        end
      end
      S_B0: begin
        if (rx_valid) begin
`ifdef SPI_FRAME_CHECKSUM_EN
          b_d[DATA_WIDTH-1:0] = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = S_CHK;
`else
          // Operands are latched on the way into S_LAUNCH so they change in
          // the same cycle core_start is high.
          core_op_d = op_q;
          core_a_d  = a_q;
          core_b_d  = {b_q[OPERAND_WIDTH-1 -: DATA_WIDTH], rx_data};
          state_d   = S_LAUNCH;
`endif
        end
      end
`ifdef SPI_FRAME_CHECKSUM_EN
      S_CHK: begin
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            core_op_d = op_q;
            core_a_d  = a_q;
            core_b_d  = b_q;
            state_d   = S_LAUNCH;
          end else begin
            err_set = 1'b1;
            state_d = S_DISCARD;
          end
        end
      end
`endif
      // If the frame already ended on the launch byte there is no further EOF
      // to wait for, so go straight back to S_CMD.
      S_LAUNCH:  state_d = eof_seen_q ? S_CMD : S_DISCARD;
      S_DISCARD: state_d = S_DISCARD;
      default:   state_d = S_CMD;
    endcase

    // The byte of this cycle is processed first; EOF then judges the result.
    partial_frame = (state_d == S_A1) || (state_d == S_A0) ||
`ifdef SPI_FRAME_CHECKSUM_EN
                    (state_d == S_CHK) ||
`endif
                    (state_d == S_B1) || (state_d == S_B0);
    if (eof_pulse) begin
      if (partial_frame) begin
        abort_set = 1'b1;
      end
      if (state_d == S_LAUNCH) begin
        eof_seen_d = 1'b1;
      end else begin
        state_d = S_CMD;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result capture, sticky flags, read pointer and transmit byte
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_clear = tx_req && (rd_ptr_q == 3'd0);

    // Set has priority over read-to-clear.
    done_d  = core_done || (done_q && !rd_clear);
    err_d   = err_set   || (err_q && !rd_clear);
    abort_d = abort_set || (abort_q && !rd_clear);

    x_d = core_done ? core_x : x_q;
    y_d = core_done ? core_y : y_q;

    rd_ptr_d = rd_ptr_q;
    if (eof_pulse) begin
      rd_ptr_d = 3'd0;
    end else if (tx_req && (rd_ptr_q != RD_LAST)) begin
      rd_ptr_d = rd_ptr_q + 3'd1;
    end

    // Built from next-state values so tx_data tracks a capture or pointer
    // move with exactly one register stage.
    status_byte = {core_busy, done_d, err_d, abort_d, 4'b0000};
    case (rd_ptr_d)
      3'd0:    tx_data_d = status_byte;
      3'd1:    tx_data_d = x_d[OPERAND_WIDTH-1 -: DATA_WIDTH];
      3'd2:    tx_data_d = x_d[DATA_WIDTH-1:0];
      3'd3:    tx_data_d = y_d[OPERAND_WIDTH-1 -: DATA_WIDTH];
      3'd4:    tx_data_d = y_d[DATA_WIDTH-1:0];
      default: tx_data_d = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (rst) begin
      cs_meta_q  <= 1'b1;
      cs_sync_q  <= 1'b1;
      cs_prev_q  <= 1'b1;
      state_q    <= S_CMD;
      eof_seen_q <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
`ifdef SPI_FRAME_CHECKSUM_EN
      chk_q      <= '0;
`endif
      core_op_q  <= '0;
      core_a_q   <= '0;
      core_b_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
      rd_ptr_q   <= '0;
      tx_data_q  <= '0;
    end else begin
      cs_meta_q  <= cs_n;
      cs_sync_q  <= cs_meta_q;
      cs_prev_q  <= cs_sync_q;
      state_q    <= state_d;
      eof_seen_q <= eof_seen_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
`ifdef SPI_FRAME_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
      core_op_q  <= core_op_d;
      core_a_q   <= core_a_d;
      core_b_q   <= core_b_d;
      x_q        <= x_d;
      y_q        <= y_d;
      done_q     <= done_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign core_op    = core_op_q;
  assign core_a     = core_a_q;
  assign core_b     = core_b_q;
  assign core_start = (state_q == S_LAUNCH);

endmodule

// File: tb/tb_spi_cordic_framer.sv
// -----------------------------------------------------------------------------
// tb_spi_cordic_framer
//
// Scoreboard bench for spi_cordic_framer. Stimulus tasks update a frame-level
// reference model (flags, results, read pointer) and push expected launches
// and expected transmit bytes into queues; a monitor on the falling clock edge
// pops and compares whenever core_start or tx_req is seen.
// Define SPI_FRAME_CHECKSUM_EN for both bench and RTL to test 6-byte frames.
// -----------------------------------------------------------------------------
module tb_spi_cordic_framer;

`ifdef SPI_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = 6;
`else
  localparam int FRAME_LEN = 5;
`endif

  logic        clk = 1'b0;
  logic        rst, cs_n, rx_valid, tx_req, core_busy, core_done;
  logic [7:0]  rx_data, tx_data;
  logic [1:0]  core_op;
  logic [15:0] core_a, core_b, core_x, core_y;
  logic        core_start;

  spi_cordic_framer dut (
    .clk(clk), .rst(rst), .cs_n(cs_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_req(tx_req),
    .tx_data(tx_data), .core_op(core_op), .core_a(core_a), .core_b(core_b),
    .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
    .core_x(core_x), .core_y(core_y)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          cyc;
  } launch_t;

  launch_t    launch_q[$];
  logic [7:0] tx_exp_q[$];
  logic [7:0] frm[$];

  // Reference model of the framer's externally visible state.
  bit          m_done, m_err, m_abort;
  logic [15:0] m_x, m_y;
  int          m_ptr;
  logic [1:0]  m_op;
  logic [15:0] m_a, m_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_done = 0; m_err = 0; m_abort = 0;
    m_x = 0; m_y = 0; m_ptr = 0;
    m_op = 0; m_a = 0; m_b = 0;
  endtask

  function automatic logic [7:0] model_byte();
    case (m_ptr)
      0:       return {core_busy, m_done, m_err, m_abort, 4'b0000};
      1:       return m_x[15:8];
      2:       return m_x[7:0];
      3:       return m_y[15:8];
      4:       return m_y[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: compares DUT outputs against the queued expectations.
  // ---------------------------------------------------------------------------
  launch_t mon_l;
  always @(negedge clk) begin
    if (!rst) begin
      if (core_start) begin
        if (launch_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_start: core_start=1 at cycle %0d, expected 0", cyc);
        end else begin
          mon_l = launch_q.pop_front();
          check("start_cycle", cyc, mon_l.cyc);
          check("core_op", {30'd0, core_op}, {30'd0, mon_l.op});
          check("core_a", {16'd0, core_a}, {16'd0, mon_l.a});
          check("core_b", {16'd0, core_b}, {16'd0, mon_l.b});
        end
      end
      if (tx_req) begin
        if (tx_exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected: tx_req with no expected byte, tx_data=0x%0h", tx_data);
        end else begin
          check("tx_data", {24'd0, tx_data}, {24'd0, tx_exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers; all drive at 1 ns after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic build_write(input logic [7:0] cmd, input logic [15:0] a,
                             input logic [15:0] b, input bit corrupt);
    frm.delete();
    frm.push_back(cmd);
    frm.push_back(a[15:8]);
    frm.push_back(a[7:0]);
    frm.push_back(b[15:8]);
    frm.push_back(b[7:0]);
`ifdef SPI_FRAME_CHECKSUM_EN
    frm.push_back(cmd ^ a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0] ^ {7'd0, corrupt});
`else
    if (corrupt) frm.push_back(8'h00);  // trailing byte, must be ignored
`endif
  endtask

  // Sends frm inside one chip-select window. With overlap, cs_n rises so that
  // the synchronized end of frame coincides with the last byte.
  task automatic send_frame(input bit overlap);
    logic [1:0] op;
    bit         launch, err, abort;
    logic [7:0] x;
    launch_t    e;
    op = frm[0][7:6];
    launch = 0; err = 0; abort = 0;
    if (op == 2'b10 || (op != 2'b11 && core_busy)) begin
      err = 1;
    end else if (op != 2'b11) begin
      if (frm.size() >= FRAME_LEN) begin
        launch = 1;
`ifdef SPI_FRAME_CHECKSUM_EN
        x = frm[0] ^ frm[1] ^ frm[2] ^ frm[3] ^ frm[4];
        if (frm[5] != x) begin
          launch = 0;
          err    = 1;
        end
`endif
      end else begin
        abort = 1;
      end
    end
    cs_n = 1'b0;
    tick(3);
    for (int i = 0; i < frm.size(); i++) begin
      if (overlap && i == frm.size() - 1) begin
        cs_n = 1'b1;
        tick(2);
      end
      if (launch && i == FRAME_LEN - 1) begin
        e.op = op; e.a = {frm[1], frm[2]}; e.b = {frm[3], frm[4]}; e.cyc = cyc + 1;
        launch_q.push_back(e);
        m_op = e.op; m_a = e.a; m_b = e.b;
      end
      send_byte(frm[i], overlap ? 0 : $urandom_range(0, 2));
    end
    cs_n = 1'b1;
    tick(6);
    m_ptr = 0;
    if (err)   m_err = 1;
    if (abort) m_abort = 1;
    check("core_op_hold", {30'd0, core_op}, {30'd0, m_op});
    check("core_a_hold", {16'd0, core_a}, {16'd0, m_a});
    check("core_b_hold", {16'd0, core_b}, {16'd0, m_b});
  endtask

  task automatic core_complete(input logic [15:0] x, input logic [15:0] y);
    core_x = x; core_y = y; core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    tick(2);
    m_done = 1; m_x = x; m_y = y;
  endtask

  // One tx_req; optionally a core_done in the very same cycle.
  task automatic tx_read(input bit with_done, input logic [15:0] x, input logic [15:0] y);
    tx_exp_q.push_back(model_byte());
    if (m_ptr == 0) begin
      m_done = 0; m_err = 0; m_abort = 0;
    end
    if (m_ptr < 5) m_ptr++;
    if (with_done) begin
      m_done = 1; m_x = x; m_y = y;
      core_x = x; core_y = y; core_done = 1'b1;
    end
    tx_req = 1'b1;
    tick(1);
    tx_req = 1'b0;
    core_done = 1'b0;
    tick($urandom_range(1, 2));
  endtask

  // Read frame: READ command, n tx_req pulses, optional core_done on pulse k.
  task automatic read_frame(input int n, input int done_at, input logic [15:0] x,
                            input logic [15:0] y);
    cs_n = 1'b0;
    tick(3);
    send_byte(8'hC0, 1);
    for (int i = 0; i < n; i++) tx_read(i == done_at, x, y);
    cs_n = 1'b1;
    tick(6);
    m_ptr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cs_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_req = 1'b0;
    core_busy = 1'b0; core_done = 1'b0; core_x = 16'h0; core_y = 16'h0;
    model_reset();
    tick(3);
    check("rst_tx_data", {24'd0, tx_data}, 32'h0);
    check("rst_core_op", {30'd0, core_op}, 32'h0);
    check("rst_core_a", {16'd0, core_a}, 32'h0);
    check("rst_core_b", {16'd0, core_b}, 32'h0);
    check("rst_core_start", {31'd0, core_start}, 32'h0);
    rst = 1'b0;
    tick(3);

    // Basic launch, result capture and full readback.
    build_write(8'h00, 16'h1234, 16'hABCD, 0);
    send_frame(0);
    core_complete(16'h0F0F, 16'hF0F0);
    read_frame(6, -1, 16'h0, 16'h0);   // 40 0F 0F F0 F0 00
    read_frame(1, -1, 16'h0, 16'h0);   // 00 after read-to-clear

    // Command while the core is busy: err, no launch, status 0xA0.
    core_busy = 1'b1;
    tick(2);
    build_write(8'h40, 16'h5555, 16'hAAAA, 0);
    send_frame(0);
    read_frame(1, -1, 16'h0, 16'h0);
    core_busy = 1'b0;
    tick(2);

    // Partial frame aborts (status 0x10); a full frame then launches.
    frm = '{8'h40, 8'h11};
    send_frame(0);
    read_frame(1, -1, 16'h0, 16'h0);
    build_write(8'h7F, 16'h8001, 16'h7FFE, 0);
    send_frame(0);

    // core_done coinciding with the status-byte tx_req: done survives.
    read_frame(2, 0, 16'h1357, 16'h2468);
    read_frame(5, -1, 16'h0, 16'h0);

    // Last byte and end of frame in the same cycle, then a normal frame.
    build_write(8'h00, 16'hCAFE, 16'hBEEF, 0);
    send_frame(1);
    build_write(8'h40, 16'h0001, 16'hFFFF, 0);
    send_frame(0);

`ifdef SPI_FRAME_CHECKSUM_EN
    frm = '{8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_frame(0);
    frm = '{8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    send_frame(0);
    read_frame(1, -1, 16'h0, 16'h0);   // 0x20
`endif

    // Reset in the cycle the launch would be visible: cancelled, all cleared.
    core_complete(16'h4321, 16'h8765);
    cs_n = 1'b0;
    tick(3);
    build_write(8'h00, 16'h7777, 16'h9999, 0);
    for (int i = 0; i < FRAME_LEN - 1; i++) send_byte(frm[i], 0);
    rx_data = frm[FRAME_LEN-1];
    rx_valid = 1'b1;
    tick(1);
    rst = 1'b1;
    rx_valid = 1'b0;
    #1;
    check("rst_mid_start", {31'd0, core_start}, 32'h0);
    check("rst_mid_core_a", {16'd0, core_a}, 32'h0);
    model_reset();
    tick(2);
    cs_n = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    read_frame(6, -1, 16'h0, 16'h0);
    build_write(8'h40, 16'h0F00, 16'h00F0, 0);
    send_frame(0);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      int          kind, sel, r;
      logic [1:0]  op;
      logic [15:0] ra, rb;
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        core_busy = ($urandom_range(0, 4) == 0);
        tick(2);
        sel = $urandom_range(0, 7);
        op  = (sel == 0) ? 2'b10 : (sel == 1) ? 2'b11 : 2'($urandom_range(0, 1));
        ra  = 16'($urandom);
        rb  = 16'($urandom);
        build_write({op, 6'($urandom)}, ra, rb, $urandom_range(0, 3) == 0);
        r = $urandom_range(0, 7);
        if (r == 0) begin
          sel = $urandom_range(1, FRAME_LEN - 1);
          while (frm.size() > sel) void'(frm.pop_back());
        end
        if (r == 1) frm.push_back(8'($urandom));
        if (r == 2) while (frm.size() > FRAME_LEN) void'(frm.pop_back());
        send_frame(r == 2);
        core_busy = 1'b0;
        tick(2);
      end else if (kind <= 7) begin
        read_frame($urandom_range(1, 6), -1, 16'h0, 16'h0);
      end else if (kind == 8) begin
        core_complete(16'($urandom), 16'($urandom));
      end else begin
        read_frame($urandom_range(1, 6), $urandom_range(0, 4), 16'($urandom), 16'($urandom));
      end
    end

    tick(10);
    check("launch_q_drained", launch_q.size(), 0);
    check("tx_q_drained", tx_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
